// File: rtl/bundle_pkg.sv
// Shared frontend/backend payload types and the default frontend-to-backend FIFO depth.
package bundle;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned FLEN          = 64;
  localparam int unsigned FB_FIFO_DEPTH = 4;

  // One decoded instruction leaving the ISU, with operands read at issue time
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      rd;
    logic [XLEN-1:0] gpr_rs;
    logic [FLEN-1:0] fpr_rs;
  } frontend_packet_t;

endpackage

// File: rtl/frontend_backend_fifo.sv
// Decoupling FIFO between the frontend ISU output and the backend issue input.
// The frontend sees fifo_full as backend_busy; a redirect flush drops everything in flight.
module frontend_backend_fifo
  import bundle::*;
#(
  parameter int unsigned DEPTH = FB_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  frontend_packet_t           in_packet,
  output logic                       fifo_full,
  output frontend_packet_t           out_packet,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  frontend_packet_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             enq;
  logic             deq;

  // Status is decoded from the registered count so reset clears it without an edge
  always_comb begin
    out_valid  = (count != '0);
    fifo_full  = (count == CNT_W'(DEPTH));
    out_packet = out_valid ? mem[rd_ptr] : '0;
    enq        = in_packet.valid & ~fifo_full & ~flush;
    deq        = out_valid & out_ready & ~flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq && !deq)      count <= count + CNT_W'(1);
      else if (deq && !enq) count <= count - CNT_W'(1);
    end
  end

  // Flop storage; contents survive flush and reset, only the pointers are cleared
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_packet;
  end

endmodule

// File: tb/tb_frontend_backend_fifo.sv
// Randomised self-checking bench for frontend_backend_fifo against a queue model.
module tb_frontend_backend_fifo;
  import bundle::*;

  localparam int unsigned DEPTH = FB_FIFO_DEPTH;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  frontend_packet_t in_packet;
  logic             fifo_full;
  frontend_packet_t out_packet;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  frontend_packet_t mq[$];
  frontend_packet_t obs_q[$];
  frontend_packet_t exp_q[$];

  always #5 clk = ~clk;

  frontend_backend_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_packet(in_packet),
    .fifo_full(fifo_full), .out_packet(out_packet), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  function automatic frontend_packet_t mk(input logic [31:0] pc);
    frontend_packet_t p;
    p.valid  = 1'b1;
    p.pc     = pc;
    p.inst   = $urandom;
    p.rd     = 5'($urandom);
    p.gpr_rs = $urandom;
    p.fpr_rs = {$urandom, $urandom};
    return p;
  endfunction

  // Advance one clock; the queue model applies the FIFO rules to the pre-edge inputs
  task automatic step();
    bit e, d;
    e = in_packet.valid && (mq.size() < DEPTH) && !flush;
    d = (mq.size() != 0) && out_ready && !flush;
    if (out_valid && out_ready && !flush) obs_q.push_back(out_packet);
    if (d) exp_q.push_back(mq[0]);
    @(posedge clk);
    #1;
    if (flush) mq.delete();
    else begin
      if (d) void'(mq.pop_front());
      if (e) mq.push_back(in_packet);
    end
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    out_ready = 1'b0;
    in_packet = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    n_cmp++; if (count !== '0)      begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_fifo_full got %b want 0", fifo_full); end
    n_cmp++; if (out_packet !== '0)  begin n_err++; $display("FAIL reset_out_packet got %h want 0", out_packet); end
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_packet = mk(32'h1000 + 32'(4 * i));
      if (i == 0) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL no_fallthrough out_valid got %b want 0", out_valid); end
      end
      step();
      if (i == 0) begin
        n_cmp++; if (out_valid !== 1'b1 || out_packet !== mq[0]) begin n_err++; $display("FAIL first_visible got %b/%h want 1/%h", out_valid, out_packet, mq[0]); end
      end
    end
    in_packet = '0;
    n_cmp++; if (count !== CNT_W'(4))   begin n_err++; $display("FAIL fill_count got %0d want 4", count); end
    n_cmp++; if (fifo_full !== 1'b1)     begin n_err++; $display("FAIL fill_fifo_full got %b want 1", fifo_full); end
    n_cmp++; if (out_packet.pc !== 32'h1000) begin n_err++; $display("FAIL fill_head_pc got %h want 1000", out_packet.pc); end
  endtask

  task automatic test_full_deq();
    obs_q.delete(); exp_q.delete();
    in_packet = mk(32'h1010);
    out_ready = 1'b1;
    step();
    in_packet = '0;
    n_cmp++; if (count !== CNT_W'(3)) begin n_err++; $display("FAIL fulldeq_count got %0d want 3", count); end
    n_cmp++; if (fifo_full !== 1'b0)  begin n_err++; $display("FAIL fulldeq_fifo_full got %b want 0", fifo_full); end
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    n_cmp++; if (obs_q.size() != 4) begin n_err++; $display("FAIL fulldeq_drained got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i].pc !== 32'h1000 + 32'(4 * i)) begin n_err++; $display("FAIL fulldeq_order[%0d] got %h want %h", i, obs_q[i].pc, 32'h1000 + 32'(4 * i)); end
    end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL fulldeq_empty got %0d want 0", count); end
  endtask

  task automatic test_stream();
    bit saw_full = 1'b0;
    bit bad_cnt  = 1'b0;
    obs_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_packet = (i < 10) ? mk(32'h3000 + 32'(4 * i)) : '0;
      step();
      if (fifo_full) saw_full = 1'b1;
      if (count > CNT_W'(1)) bad_cnt = 1'b1;
    end
    in_packet = '0;
    out_ready = 1'b0;
    n_cmp++; if (saw_full) begin n_err++; $display("FAIL stream_fifo_full got 1 want 0"); end
    n_cmp++; if (bad_cnt)  begin n_err++; $display("FAIL stream_count got >1 want <=1"); end
    n_cmp++; if (obs_q.size() != 10) begin n_err++; $display("FAIL stream_len got %0d want 10", obs_q.size()); end
    for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i] || obs_q[i].pc !== 32'h3000 + 32'(4 * i)) begin n_err++; $display("FAIL stream_pkt[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin in_packet = mk(32'h4000 + 32'(4 * i)); step(); end
    in_packet = mk(32'h4FF0);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    in_packet = '0;
    out_ready = 1'b0;
    n_cmp++; if (count !== '0)       begin n_err++; $display("FAIL flush_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    obs_q.delete(); exp_q.delete();
    in_packet = mk(32'h2000);
    step();
    in_packet = '0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (obs_q.size() != 1 || obs_q[0].pc !== 32'h2000) begin n_err++; $display("FAIL flush_next_pc got n=%0d want pc 2000", obs_q.size()); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin in_packet = mk(32'h5000 + 32'(4 * i)); step(); end
    in_packet = '0;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (count !== '0)       begin n_err++; $display("FAIL arst_count got %0d want 0", count); end
    n_cmp++; if (out_packet !== '0)  begin n_err++; $display("FAIL arst_out_packet got %h want 0", out_packet); end
    #1;
    rst = 1'b0;
    mq.delete();
    out_ready = 1'b1;
    step(); step();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_stays_empty got %b want 0", out_valid); end
  endtask

  task automatic test_random_bubbles();
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      in_packet = ($urandom_range(0, 2) != 0) ? mk($urandom) : '0;
      if (!in_packet.valid) in_packet.pc = $urandom;
      out_ready = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 40) == 0);
      step();
      n_cmp++; if (count !== CNT_W'(mq.size())) begin n_err++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, count, mq.size()); end
      n_cmp++; if (fifo_full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full cyc %0d got %b", i, fifo_full); end
      n_cmp++; if (out_packet !== ((mq.size() != 0) ? mq[0] : frontend_packet_t'('0))) begin n_err++; $display("FAIL rnd_head cyc %0d got %h", i, out_packet); end
    end
    idle_inputs();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd_deq_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_order[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_deq();
    test_stream();
    test_flush();
    test_async_reset();
    test_random_bubbles();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frontend_backend_fifo.md
FRONTEND_BACKEND_FIFO -- requirements
Module: frontend_backend_fifo

Interface
REQ-001 The module SHALL take parameter DEPTH, default 4, giving the number of frontend_packet_t entries; it must be a power of two and at least 2.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port flush, input, 1 bit: pipeline flush from backend redirect.
REQ-005 The module SHALL have port in_packet, input, frontend_packet_t: the ISU output packet; its valid field qualifies it.
REQ-006 The module SHALL have port fifo_full, output, 1 bit: drives the Frontend backend_busy input, so the frontend holds in_packet while it is high.
REQ-007 The module SHALL have port out_packet, output, frontend_packet_t: head entry presented to the backend.
REQ-008 The module SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-009 The module SHALL have port out_ready, input, 1 bit: the backend accepts the head this cycle.
REQ-010 The module SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-011 enq SHALL equal in_packet.valid & ~fifo_full & ~flush; when enq is true, in_packet is written at wr_ptr and wr_ptr advances by 1.
REQ-012 deq SHALL equal out_valid & out_ready & ~flush; when deq is true, rd_ptr advances by 1.
REQ-013 Pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case at DEPTH-1.
REQ-014 count SHALL update as +1 on enq only, -1 on deq only, and unchanged on both or neither.
REQ-015 fifo_full SHALL be (count == DEPTH) and combinational from registered count, with no dependence on out_ready in the same cycle.
REQ-016 out_valid SHALL be (count != 0); out_packet SHALL be mem[rd_ptr] when out_valid, else all zeros.
REQ-017 The latency from enqueue to visibility on out_packet SHALL be 1 cycle minimum, with no fall-through path when empty.
REQ-018 When empty, simultaneous enq and out_ready SHALL enqueue only, and count becomes 1.
REQ-019 When full, in_packet SHALL be ignored even if deq occurs that cycle; count becomes DEPTH-1 and fifo_full drops the next cycle.
REQ-020 Flush SHALL take priority: on the next edge wr_ptr, rd_ptr and count are cleared, the in_packet and out_ready of the flush cycle are discarded, and out_valid is 0 the following cycle.
REQ-021 Storage contents SHALL NOT be cleared on flush; only the pointers and count are cleared.
REQ-022 Packets SHALL leave in strict FIFO order, bit-exact, including gpr_rs/fpr_rs values captured at enqueue.
REQ-023 When in_packet.valid is 0, a bubble from the frontend, nothing SHALL be stored.

Reset
REQ-024 On rst, the pointers and count SHALL be 0 and out_valid, fifo_full and out_packet SHALL be 0 immediately, without waiting for a clock edge.
REQ-025 A reset asserted mid-operation SHALL abandon all stored entries; no entry is presented after rst deasserts until a new enq.

Structure
REQ-026 frontend_packet_t SHALL remain in package bundle; the default depth constant FB_FIFO_DEPTH SHALL be added to bundle.
REQ-027 The module SHALL be a single module with no sub-modules; the storage array is a flop-based register array, not a RAM macro.
REQ-028 The module SHALL be instantiated between Frontend.frontend_packet and the backend issue input, with fifo_full wired to Frontend.backend_busy.

Verification
REQ-029 Reset then 4 valid packets with pc 0x1000, 0x1004, 0x1008, 0x100C and out_ready=0 -> count=4, fifo_full=1 after the 4th edge, out_packet.pc=0x1000.
REQ-030 Full FIFO with out_ready=1 and in_packet.valid=1 (pc 0x1010) in the same cycle -> pc 0x1000 dequeued, 0x1010 not stored, count=3, fifo_full=0.
REQ-031 Streaming of 10 packets with out_ready=1 every cycle -> pcs exit in order across 2 pointer wraps, count oscillates 0/1, and fifo_full is never asserted.
REQ-032 Flush with 3 entries and a valid in_packet that cycle -> count=0 and out_valid=0 next cycle; the next enqueued pc 0x2000 is the first dequeued.
REQ-033 rst pulse between clock edges with 2 entries -> out_valid=0 and count=0 asynchronously, and out_packet is all zeros.
REQ-034 Bubbles (in_packet.valid=0) interleaved with valid packets -> only the valid packets are counted and emitted.
